sort_stage_ctrl: RTL
====================

// Module: sort_stage_ctrl
// PURPOSE
//  Iteration controller wrapped around the combinational sort_stage.
//  - Accepts one vector of M words (N bits each) on a valid/ready input.
//  - Holds the vector in a working register and drives it into sort_stage.
//  - Each fire writes back the stage's modified vector and emits the
//    extracted minimum o_y_q on a registered valid/ready output stream.
//  - Emits exactly M words per vector, ascending; the last one is flagged.
// PARAMETERS
//  M   sort_pkg::M  number of words per vector (M >= 1)
//  N   sort_pkg::N  word width in bits
//  CW  $clog2(M+1)  localparam, width of the extraction counter
// PORTS
//  i_clk         in   1      clock; all state updates on the rising edge
//  i_rst_n       in   1      asynchronous active-low reset
//  i_chi         in   [M][N] input vector
//  i_valid       in   1      input vector valid
//  o_ready       out  1      input ready; high only in IDLE
//  o_stage_chi   out  [M][N] working register, feeds sort_stage.i_chi
//  i_stage_chi   in   [M][N] sort_stage.o_chi (modified vector)
//  i_stage_y_q   in   N      sort_stage.o_y_q (current minimum)
//  o_y           out  N      sorted output word (registered)
//  o_y_valid     out  1      output word valid
//  o_y_last      out  1      marks the M-th word of a vector
//  i_y_ready     in   1      downstream ready
//  o_busy        out  1      high in state RUN or DRAIN
// BEHAVIOUR
//  Reset (async assert, sync deassert by the system):
//   state=IDLE; cnt=0; working reg=0; o_y=0; o_y_valid=0; o_y_last=0;
//   o_ready=1; o_busy=0.
//  FSM:
//   IDLE : i_valid & o_ready -> load i_chi into the working reg; cnt=0; go RUN.
//   RUN  : fire = !o_y_valid | i_y_ready. On fire:
//          o_y <= i_stage_y_q; o_y_valid <= 1; o_y_last <= (cnt==M-1);
//          working reg <= i_stage_chi; cnt <= cnt+1.
//          If cnt==M-1 on fire -> DRAIN.
//          No fire -> hold all state; o_y, o_y_valid and o_y_last stay stable.
//   DRAIN: i_y_ready & o_y_valid -> o_y_valid=0, o_y_last=0, go IDLE.
//  Output rules:
//   - Words are consumed when o_y_valid & i_y_ready on the same edge.
//   - While o_y_valid=1 & i_y_ready=0, o_y/o_y_last are held unchanged.
//  Latency and throughput:
//   - Input accepted at edge 0 -> first o_y_valid at edge 2.
//   - Full throughput: one word per cycle.
//   - Vector period is M+2 cycles with i_y_ready tied high.
//  Boundaries:
//   - M=1: the first fire sets o_y_last=1 and goes straight to DRAIN.
//   - i_valid outside IDLE is ignored (o_ready=0); no input data is lost.
//   - Duplicate values are emitted once per occurrence.
//   - cnt never exceeds M-1 in RUN; counting is sequence-based only, no
//     value-based termination.
//   - Reset mid-vector: the vector is discarded; outputs return to reset
//     values immediately (async).
//  Arithmetic: none on data; words pass unmodified and unsigned.
// TESTING  (bench: M=4, N=8, real sort_stage instance in the loop)
//  1. i_chi={0x30,0x05,0xFF,0x05}, i_y_ready=1 -> o_y 0x05,0x05,0x30,0xFF
//     on consecutive cycles, o_y_last on 0xFF, o_ready back high after 6 cycles.
//  2. Same vector, i_y_ready low for 3 cycles after the first word ->
//     0x05 held stable, no word lost or duplicated, order unchanged.
//  3. All-equal {0x7A x4} -> four 0x7A words, last on the 4th,
//     returns to IDLE.
//  4. i_valid held high across two vectors {1,2,3,4},{9,8,7,6} ->
//     second vector accepted only in IDLE; outputs 1,2,3,4 then 6,7,8,9.
//  5. i_rst_n pulsed low after 2 words -> o_y_valid=0, o_busy=0, o_ready=1
//     asynchronously; the next vector sorts correctly.
//  6. Boundary values {0x00,0xFF,0x00,0xFF} -> 0x00,0x00,0xFF,0xFF
//     with correct last flag.

Source files
------------

// File: rtl/sort_stage_ctrl.sv
// rtl/sort_stage_ctrl.sv - sort_pkg, combinational sort_stage and its iteration controller sort_stage_ctrl
//
// sort_pkg        : default vector geometry (M words of N bits).
// sort_stage      : combinational min-extraction stage.
//   i_chi  in  [M][N] vector under sort
//   o_chi  out [M][N] i_chi with the extracted minimum replaced by all-ones
//   o_y_q  out N      minimum word of i_chi
// sort_stage_ctrl : loads one vector, iterates it through sort_stage M times
//                   and streams the extracted minima out in ascending order.
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_chi, i_valid        input vector and its valid
//   o_ready               input ready (IDLE only)
//   o_stage_chi           working register, drives sort_stage.i_chi
//   i_stage_chi           sort_stage.o_chi
//   i_stage_y_q           sort_stage.o_y_q
//   o_y, o_y_valid        registered output word stream
//   o_y_last              marks the M-th word of a vector
//   i_y_ready             downstream ready
//   o_busy                high in RUN or DRAIN

package sort_pkg;
  localparam int M = 4;
  localparam int N = 8;
endpackage

module sort_stage #(
  parameter int M = sort_pkg::M,
  parameter int N = sort_pkg::N
) (
  input  logic [M-1:0][N-1:0] i_chi,
  output logic [M-1:0][N-1:0] o_chi,
  output logic [N-1:0]        o_y_q
);

  logic [N-1:0] min_val;
  int           min_idx;

  // Lowest index wins on ties so duplicates are extracted one per pass.
  always_comb begin
    min_val = i_chi[0];
    min_idx = 0;
    for (int i = 1; i < M; i++) begin
      if (i_chi[i] < min_val) begin
        min_val = i_chi[i];
        min_idx = i;
      end
    end
  end

  // The extracted slot becomes all-ones; the controller counts passes, so a
  // genuine all-ones word and a spent slot are interchangeable.
  always_comb begin
    o_chi = i_chi;
    for (int i = 0; i < M; i++) begin
      if (i == min_idx) begin
        o_chi[i] = '1;
      end
    end
    o_y_q = min_val;
  end

endmodule

module sort_stage_ctrl #(
  parameter int M = sort_pkg::M,
  parameter int N = sort_pkg::N
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [M-1:0][N-1:0] i_chi,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [M-1:0][N-1:0] o_stage_chi,
  input  logic [M-1:0][N-1:0] i_stage_chi,
  input  logic [N-1:0]        i_stage_y_q,
  output logic [N-1:0]        o_y,
  output logic                o_y_valid,
  output logic                o_y_last,
  input  logic                i_y_ready,
  output logic                o_busy
);

  localparam int CW = $clog2(M + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [M-1:0][N-1:0]  work_nxt;
  logic [N-1:0]         y_nxt;
  logic                 y_valid_nxt;
  logic                 y_last_nxt;
  logic                 fire;
  logic                 final_pass;

  // A new word may be produced when the output slot is empty or being drained.
  assign fire       = !o_y_valid || i_y_ready;
  assign final_pass = (cnt == CW'(M - 1));

  assign o_ready = (state == IDLE);
  assign o_busy  = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      o_stage_chi <= '0;
      o_y         <= '0;
      o_y_valid   <= 1'b0;
      o_y_last    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      o_stage_chi <= work_nxt;
      o_y         <= y_nxt;
      o_y_valid   <= y_valid_nxt;
      o_y_last    <= y_last_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    work_nxt    = o_stage_chi;
    y_nxt       = o_y;
    y_valid_nxt = o_y_valid;
    y_last_nxt  = o_y_last;

    case (state)
      IDLE: begin
        if (i_valid) begin
          work_nxt  = i_chi;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end

      RUN: begin
        if (fire) begin
          y_nxt       = i_stage_y_q;
          y_valid_nxt = 1'b1;
          y_last_nxt  = final_pass;
          work_nxt    = i_stage_chi;
          cnt_nxt     = cnt + CW'(1);
          if (final_pass) begin
            state_nxt = DRAIN;
          end
        end
      end

      DRAIN: begin
        // Only the flagged last word is left; wait for it to be taken.
        if (i_y_ready && o_y_valid) begin
          y_valid_nxt = 1'b0;
          y_last_nxt  = 1'b0;
          state_nxt   = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
